// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: FSM states, key-length encodings,
// the Rcon table and the Nk/Nr lookups derived from the key length.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [1:0] MODE_128  = 2'd0;
    localparam logic [1:0] MODE_192  = 2'd1;
    localparam logic [1:0] MODE_256  = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    function automatic logic [3:0] mode_nk(input logic [1:0] mode);
        case (mode)
            MODE_128: return 4'd4;
            MODE_192: return 4'd6;
            MODE_256: return 4'd8;
            default:  return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] mode_nr(input logic [1:0] mode);
        case (mode)
            MODE_128: return 4'd10;
            MODE_192: return 4'd12;
            MODE_256: return 4'd14;
            default:  return 4'd0;
        endcase
    endfunction

    function automatic logic [7:0] rcon_lookup(input logic [3:0] idx);
        return (idx < 4'd10) ? RCON[idx] : 8'h00;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box for a single byte.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/key_expansion_multi.sv
// AES key expansion for 128/192/256-bit keys: loads the key words in one
// cycle, then derives one schedule word per cycle into a word array.
module key_expansion_multi
    import aes_pkg::*;
#(
    parameter int MAX_NK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_mode,
    input  logic [255:0] key,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         key_valid,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key
);

    localparam int DEPTH = 4 * (MAX_NK + 7);

    state_e         state_q, state_d;
    logic [255:0]   key_q, key_d;
    logic [3:0]     nk_q, nk_d, nr_q, nr_d, rd_nr_q, rd_nr_d, rc_q, rc_d;
    logic [5:0]     idx_q, idx_d;
    logic [2:0]     mod_q, mod_d;
    logic           done_q, done_d, err_q, err_d, kv_q, kv_d;
    logic [127:0]   rd_key_q, rd_key_d;

    logic [31:0]    w_mem [DEPTH];
    logic [31:0]    prev_word, back_word, sub_in, sub_out, temp_word, new_word;
    logic [5:0]     rd_base;
    logic           mode_ok, rd_hit;

    assign mode_ok = (key_mode != MODE_RSVD) && (int'(mode_nk(key_mode)) <= MAX_NK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            key_q    <= '0;
            nk_q     <= '0;
            nr_q     <= '0;
            rd_nr_q  <= '0;
            rc_q     <= '0;
            idx_q    <= '0;
            mod_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            kv_q     <= 1'b0;
            rd_key_q <= '0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            nk_q     <= nk_d;
            nr_q     <= nr_d;
            rd_nr_q  <= rd_nr_d;
            rc_q     <= rc_d;
            idx_q    <= idx_d;
            mod_q    <= mod_d;
            done_q   <= done_d;
            err_q    <= err_d;
            kv_q     <= kv_d;
            rd_key_q <= rd_key_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start && mode_ok) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_EXPAND;
            ST_EXPAND: if (idx_q == {nr_q, 2'b11}) state_d = ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Word recurrence: w[i] = w[i-Nk] ^ f(w[i-1]); mod_q tracks i mod Nk.
    assign prev_word = w_mem[idx_q - 6'd1];
    assign back_word = w_mem[idx_q - {2'b00, nk_q}];
    assign sub_in    = (mod_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (sub_in[gi*8 +: 8]),
            .out_byte (sub_out[gi*8 +: 8])
        );
    end

    always_comb begin
        if (mod_q == 3'd0)
            temp_word = sub_out ^ {rcon_lookup(rc_q), 24'h0};
        else if ((nk_q == 4'd8) && (mod_q == 3'd4))
            temp_word = sub_out;
        else
            temp_word = prev_word;
        new_word = back_word ^ temp_word;
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_LOAD) begin
            for (int j = 0; j < MAX_NK; j++) begin
                if (4'(j) < nk_q) w_mem[j] <= key_q[255 - 32*j -: 32];
            end
        end else if (state_q == ST_EXPAND) begin
            w_mem[idx_q] <= new_word;
        end
    end

    always_comb begin
        key_d   = key_q;
        nk_d    = nk_q;
        nr_d    = nr_q;
        rd_nr_d = rd_nr_q;
        rc_d    = rc_q;
        idx_d   = idx_q;
        mod_d   = mod_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        kv_d    = kv_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (mode_ok) begin
                        key_d = key;
                        nk_d  = mode_nk(key_mode);
                        nr_d  = mode_nr(key_mode);
                    end else begin
                        err_d = 1'b1;
                        kv_d  = 1'b0;
                    end
                end
            end
            ST_LOAD: begin
                kv_d  = 1'b0;
                idx_d = {2'b00, nk_q};
                mod_d = 3'd0;
                rc_d  = 4'd0;
            end
            ST_EXPAND: begin
                idx_d = idx_q + 6'd1;
                if ({1'b0, mod_q} == nk_q - 4'd1) begin
                    mod_d = 3'd0;
                    rc_d  = rc_q + 4'd1;
                end else begin
                    mod_d = mod_q + 3'd1;
                end
            end
            default: begin
                done_d  = 1'b1;
                kv_d    = 1'b1;
                rd_nr_d = nr_q;
            end
        endcase
    end

    // Reads use the Nr of the completed schedule, not of one in progress.
    assign rd_hit  = kv_q && (rd_round <= rd_nr_q);
    assign rd_base = rd_hit ? {rd_round, 2'b00} : 6'd0;

    always_comb begin
        rd_key_d = '0;
        if (rd_hit)
            rd_key_d = {w_mem[rd_base], w_mem[rd_base + 6'd1],
                        w_mem[rd_base + 6'd2], w_mem[rd_base + 6'd3]};
    end

    assign busy      = (state_q == ST_LOAD) || (state_q == ST_EXPAND);
    assign done      = done_q;
    assign err       = err_q;
    assign key_valid = kv_q;
    assign rd_key    = rd_key_q;

endmodule

// File: tb/tb_key_expansion_multi.sv
// Directed bench for key_expansion_multi: FIPS-197 vectors per key length,
// reject, abort and busy-start sequences, plus a MAX_NK=4 instance.
module tb_key_expansion_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   key_mode = 2'd0;
    logic [255:0] key = '0;
    logic [3:0]   rd_round = 4'd0;
    logic         busy, done, err, key_valid;
    logic [127:0] rd_key;

    logic         start4 = 1'b0;
    logic [1:0]   mode4 = 2'd0;
    logic [255:0] key4 = '0;
    logic [3:0]   rd_round4 = 4'd0;
    logic         busy4, done4, err4, kv4;
    logic [127:0] rd_key4;

    key_expansion_multi #(.MAX_NK(8)) dut (
        .clk(clk), .rst(rst), .start(start), .key_mode(key_mode), .key(key),
        .busy(busy), .done(done), .err(err), .key_valid(key_valid),
        .rd_round(rd_round), .rd_key(rd_key)
    );

    key_expansion_multi #(.MAX_NK(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .key_mode(mode4), .key(key4),
        .busy(busy4), .done(done4), .err(err4), .key_valid(kv4),
        .rd_round(rd_round4), .rd_key(rd_key4)
    );

    typedef struct {
        logic [1:0]   mode;
        logic [255:0] key;
        int           lat;
        logic [3:0]   nr;
        logic [127:0] exp_r1;
        logic [127:0] exp_last;
    } run_t;

    run_t runs [4];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_key(output logic [255:0] k);
        for (int i = 0; i < 8; i++) k[i*32 +: 32] = $urandom;
    endtask

    task automatic rd_chk(input string nm, input logic [3:0] r, input logic [127:0] exp);
        rd_round = r;
        step();
        chk(nm, rd_key, exp);
    endtask

    // Start one expansion; optionally poke start again while busy.
    task automatic run_exp(input int id, input run_t r, input int poke_at, input logic prev_kv);
        int   cyc;
        logic got;
        logic [255:0] junk;
        key      = r.key;
        key_mode = r.mode;
        start    = 1'b1;
        step();
        start = 1'b0;
        rand_key(junk);
        key      = junk;
        key_mode = 2'd3;
        chk($sformatf("run%0d_kv_hold", id), key_valid, prev_kv);
        cyc = 0;
        got = 1'b0;
        while (cyc < 200 && !got) begin
            if (cyc == poke_at) begin
                start    = 1'b1;
                key_mode = 2'd2;
            end
            step();
            start = 1'b0;
            cyc++;
            if (cyc == 1)         chk($sformatf("run%0d_kv_load", id), key_valid, 1'b0);
            if (cyc == r.lat - 2) chk($sformatf("run%0d_busy_last", id), busy, 1'b1);
            if (cyc == r.lat - 1) chk($sformatf("run%0d_busy_off", id), busy, 1'b0);
            got = done;
        end
        chk($sformatf("run%0d_latency", id), 128'(cyc), 128'(r.lat));
        chk($sformatf("run%0d_kv_done", id), key_valid, 1'b1);
        step();
        chk($sformatf("run%0d_done_pulse", id), done, 1'b0);
        rd_chk($sformatf("run%0d_rd0", id), 4'd0, r.key[255:128]);
        rd_chk($sformatf("run%0d_rd1", id), 4'd1, r.exp_r1);
        rd_chk($sformatf("run%0d_rdNr", id), r.nr, r.exp_last);
        rd_chk($sformatf("run%0d_rdNr1", id), r.nr + 4'd1, 128'h0);
    endtask

    initial begin
        int   cyc;
        logic seen;

        runs[0] = '{2'd0, 256'h0, 42, 4'd10,
                    128'h62636363626363636263636362636363,
                    128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        runs[1] = '{2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 42, 4'd10,
                    128'ha0fafe1788542cb123a339392a6c7605,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        runs[2] = '{2'd1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 48, 4'd12,
                    128'h62f8ead2522c6b7bfe0c91f72402f5a5,
                    128'he98ba06f448c773c8ecc720401002202};
        runs[3] = '{2'd2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 54, 4'd14,
                    128'h1f352c073b6108d72d9810a30914dff4,
                    128'hfe4890d1e6188d0b046df344706c631e};

        step(); step(); step();
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_err", err, 1'b0);
        chk("reset_kv", key_valid, 1'b0);
        chk("reset_rd_key", rd_key, 128'h0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 4; i++)
            run_exp(i, runs[i], (i == 1) ? 10 : -1, (i != 0));

        // Reset while idle drops the finished schedule.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_idle_kv", key_valid, 1'b0);
        rd_chk("rst_idle_rd", 4'd10, 128'h0);

        // Abort mid-EXPAND, with a busy-time start and a rst+start collision.
        key = runs[1].key; key_mode = 2'd0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        start = 1'b1; key_mode = 2'd1;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("abort_busy_before", busy, 1'b1);
        rst = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_kv", key_valid, 1'b0);
        seen = 1'b0;
        repeat (60) begin
            step();
            if (done || busy) seen = 1'b1;
        end
        chk("abort_no_done", seen, 1'b0);
        run_exp(4, runs[2], -1, 1'b0);

        // Reserved mode rejected; previous schedule invalidated.
        key_mode = 2'd3; start = 1'b1;
        step();
        start = 1'b0;
        chk("mode3_err", err, 1'b1);
        chk("mode3_busy", busy, 1'b0);
        chk("mode3_kv", key_valid, 1'b0);
        step();
        chk("mode3_err_pulse", err, 1'b0);
        rd_chk("mode3_rd", 4'd0, 128'h0);

        // MAX_NK=4 instance: 256-bit rejected, 128-bit accepted.
        mode4 = 2'd2; start4 = 1'b1;
        step();
        start4 = 1'b0;
        chk("nk4_err", err4, 1'b1);
        chk("nk4_busy", busy4, 1'b0);
        chk("nk4_kv", kv4, 1'b0);
        mode4 = 2'd0; start4 = 1'b1;
        step();
        start4 = 1'b0;
        cyc = 0;
        while (cyc < 200 && !done4) begin
            step();
            cyc++;
        end
        chk("nk4_latency", 128'(cyc), 128'd42);
        rd_round4 = 4'd10;
        step();
        chk("nk4_rd10", rd_key4, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/key_expansion_multi.md
KEY_EXPANSION_MULTI -- requirements
Module: key_expansion_multi

Interface
REQ-001 SHALL have parameter MAX_NK, default 8, meaning the largest key length in 32-bit words supported (4, 6 or 8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin expansion of key.
REQ-005 SHALL have port key_mode, input, 2, key length: 0=128, 1=192, 2=256, 3=reserved.
REQ-006 SHALL have port key, input, 256, cipher key in [0:255] big-endian order; word i occupies bits [32i:32i+31]; unused trailing bits ignored.
REQ-007 SHALL have port busy, output, 1, high while in LOAD or EXPAND.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when the schedule is complete.
REQ-009 SHALL have port err, output, 1, one-cycle pulse on a rejected start.
REQ-010 SHALL have port key_valid, output, 1, high while the stored schedule is complete and readable.
REQ-011 SHALL have port rd_round, input, 4, round-key index to read.
REQ-012 SHALL have port rd_key, output, 128, round key rd_round in [0:127] order, registered.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, EXPAND, DONE; IDLE->LOAD on start; LOAD->EXPAND always; EXPAND->DONE after the last word is written; DONE->IDLE always.
REQ-014 SHALL derive Nk=4/6/8 and Nr=10/12/14 from key_mode latched at start acceptance.
REQ-015 SHALL accept start only in IDLE; start in any other state is ignored with no side effect.
REQ-016 SHALL reject start when key_mode=3 or Nk>MAX_NK: pulse err the following cycle, stay in IDLE, clear key_valid.
REQ-017 SHALL, in LOAD, write words w[0..Nk-1] from the latched key in one cycle and clear key_valid.
REQ-018 SHALL, in EXPAND, compute and write exactly one word per cycle, w[i] for i=Nk..4*Nr+3, per FIPS-197 (RotWord/SubWord/Rcon when i mod Nk=0; SubWord only when Nk=8 and i mod 8=4).
REQ-019 SHALL take Rcon from a 10-entry table indexed by i/Nk-1; word index and all XORs are modulo-free 32-bit with no carry.
REQ-020 SHALL assert done and set key_valid in DONE; start-accept edge to done-high cycle is 42/48/54 cycles for 128/192/256.
REQ-021 SHALL keep busy high from LOAD through the last EXPAND cycle inclusive, low otherwise.
REQ-022 SHALL present rd_key one cycle after rd_round is sampled, as words w[4r..4r+3].
REQ-023 SHALL return rd_key=0 when rd_round>Nr of the stored schedule or key_valid is low.
REQ-024 SHALL hold the previous schedule readable until the next accepted LOAD cycle.
REQ-025 SHALL ignore key and key_mode changes after start acceptance.

Reset
REQ-026 SHALL, on rst high at a clock edge, enter IDLE and drive busy=0, done=0, err=0, key_valid=0, rd_key=0 from the next cycle.
REQ-027 SHALL abort any expansion in progress on rst with no done pulse; word storage contents need not be cleared.
REQ-028 SHALL give rst priority over start in the same cycle.

Structure
REQ-029 SHALL place Rcon table, mode encodings, Nk/Nr lookup and FSM state typedef in shared package aes_pkg.
REQ-030 SHALL instantiate four copies of sub-module aes_sbox (combinational byte S-box) for SubWord.
REQ-031 SHALL store words in a 4*(MAX_NK+7)-entry by 32-bit register array.

Verification
REQ-032 SHALL cover all-zero key, mode 0 -> done at cycle 42, rd_round=10 gives b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-033 SHALL cover key 2b7e151628aed2a6abf7158809cf4f3c, mode 0 -> rd_round=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-034 SHALL cover key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, mode 1 -> done at cycle 48, rd_round=12 gives e98ba06f448c773c8ecc720401002202.
REQ-035 SHALL cover key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, mode 2 -> done at cycle 54, rd_round=14 gives fe4890d1e6188d0b046df344706c631e.
REQ-036 SHALL cover key_mode=3 and, with MAX_NK=4, mode 2 -> err pulse, busy stays 0, key_valid=0.
REQ-037 SHALL cover rst asserted mid-EXPAND and start while busy -> no done, key_valid=0, next clean start completes correctly.
